// File: rtl/dpdm_nrzi_bs_decode.sv
// USB full/low-speed receive front end: D+/D- line-state decode, NRZI decode,
// SYNC detection, bit unstuffing and EOP detection. One bit time per clock.
// Optional build macro RX_BS_ERROR_EN: when defined, a seventh consecutive
// one flags bs_error and aborts the packet; otherwise bs_error is tied low and
// the offending bit is dropped like a normal stuffed bit.
module dpdm_nrzi_bs_decode (
   input  logic clock,
   input  logic reset_n,
   input  logic rx_enable,
   input  logic DP,
   input  logic DM,
   output logic out_bit,
   output logic out_valid,
   output logic pkt_start,
   output logic pkt_end,
   output logic line_error,
   output logic bs_error
);

   typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

   state_t     state, state_nx;
   logic       prev_j, prev_j_nx;   // last non-SE0 level was J
   logic [2:0] cnt, cnt_nx;         // sync bit / ones run / SE0 count, by state
   logic       out_bit_nx, out_valid_nx, pkt_start_nx, pkt_end_nx, line_error_nx;
   logic       se0, se1, lvl_j, lvl_k, nrzi;

   assign se0   = ~DP & ~DM;
   assign se1   =  DP &  DM;
   assign lvl_j =  DP & ~DM;
   assign lvl_k = ~DP &  DM;
   // Same level as last time decodes to 1, a transition to 0.
   assign nrzi  = (lvl_j == prev_j);

`ifdef RX_BS_ERROR_EN
   logic bs_error_nx;
`else
   assign bs_error = 1'b0;
`endif

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      prev_j_nx     = prev_j;
      out_bit_nx    = 1'b0;
      out_valid_nx  = 1'b0;
      pkt_start_nx  = 1'b0;
      pkt_end_nx    = 1'b0;
      line_error_nx = 1'b0;
`ifdef RX_BS_ERROR_EN
      bs_error_nx   = 1'b0;
`endif
      if (!se0 && !se1)
         prev_j_nx = lvl_j;

      case (state)
         IDLE: begin
            if (rx_enable && lvl_k) begin
               state_nx = SYNC;
               cnt_nx   = 3'd1;
            end
         end
         SYNC: begin
            if (se1) begin
               line_error_nx = 1'b1;
               state_nx      = IDLE;
            end else if (se0) begin
               state_nx = IDLE;
            end else if (cnt == 3'd7) begin
               // Eighth sync bit must be the closing 1 (the KK pair).
               if (nrzi) begin
                  pkt_start_nx = 1'b1;
                  state_nx     = DATA;
                  cnt_nx       = 3'd1;
               end else begin
                  state_nx = IDLE;
               end
            end else if (!nrzi) begin
               cnt_nx = cnt + 3'd1;
            end else begin
               state_nx = IDLE;
            end
         end
         DATA: begin
            if (se1) begin
               line_error_nx = 1'b1;
               state_nx      = IDLE;
            end else if (se0) begin
               state_nx = EOP;
               cnt_nx   = 3'd1;
            end else if (cnt < 3'd6) begin
               out_valid_nx = 1'b1;
               out_bit_nx   = nrzi;
               cnt_nx       = nrzi ? cnt + 3'd1 : 3'd0;
            end else if (!nrzi) begin
               // Stuffed zero after six ones: swallow it.
               cnt_nx = 3'd0;
            end else begin
`ifdef RX_BS_ERROR_EN
               bs_error_nx = 1'b1;
               state_nx    = IDLE;
`else
               cnt_nx = 3'd0;
`endif
            end
         end
         EOP: begin
            if (cnt == 3'd1 && se0) begin
               cnt_nx = 3'd2;
            end else begin
               state_nx = IDLE;
               if (cnt == 3'd2 && lvl_j)
                  pkt_end_nx = 1'b1;
               else
                  line_error_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      // Disarming the receiver aborts quietly from any state.
      if (!rx_enable) begin
         state_nx      = IDLE;
         out_bit_nx    = 1'b0;
         out_valid_nx  = 1'b0;
         pkt_start_nx  = 1'b0;
         pkt_end_nx    = 1'b0;
         line_error_nx = 1'b0;
`ifdef RX_BS_ERROR_EN
         bs_error_nx   = 1'b0;
`endif
      end

      // IDLE always restarts NRZI history from the idle J level.
      if (state_nx == IDLE) begin
         prev_j_nx = 1'b1;
         cnt_nx    = 3'd0;
      end
   end

   // State, history and output registers with asynchronous clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         prev_j     <= 1'b1;
         cnt        <= 3'd0;
         out_bit    <= 1'b0;
         out_valid  <= 1'b0;
         pkt_start  <= 1'b0;
         pkt_end    <= 1'b0;
         line_error <= 1'b0;
      end else begin
         state      <= state_nx;
         prev_j     <= prev_j_nx;
         cnt        <= cnt_nx;
         out_bit    <= out_bit_nx;
         out_valid  <= out_valid_nx;
         pkt_start  <= pkt_start_nx;
         pkt_end    <= pkt_end_nx;
         line_error <= line_error_nx;
      end
   end

`ifdef RX_BS_ERROR_EN
   // Bit-stuff violation pulse register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) bs_error <= 1'b0;
      else          bs_error <= bs_error_nx;
   end
`endif

endmodule

// File: tb/tb_dpdm_nrzi_bs_decode.sv
// Directed bench for dpdm_nrzi_bs_decode: line states are driven per bit
// time, outputs sampled 1 time unit after each rising edge.
module tb_dpdm_nrzi_bs_decode;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic rx_enable = 1'b1;
   logic DP = 1'b1;
   logic DM = 1'b0;
   logic out_bit, out_valid, pkt_start, pkt_end, line_error, bs_error;

   int total = 0;
   int bad = 0;
   int n_valid, n_start, n_end, n_lerr, n_bserr, n_multi;
   logic [15:0] cap;
   logic tx_j;

   dpdm_nrzi_bs_decode dut (
      .clock(clock), .reset_n(reset_n), .rx_enable(rx_enable),
      .DP(DP), .DM(DM),
      .out_bit(out_bit), .out_valid(out_valid), .pkt_start(pkt_start),
      .pkt_end(pkt_end), .line_error(line_error), .bs_error(bs_error)
   );

   always #5 clock = ~clock;

   task automatic clr();
      n_valid = 0; n_start = 0; n_end = 0; n_lerr = 0; n_bserr = 0; n_multi = 0;
      cap = '0;
   endtask

   // Drive one line state for one bit time and log what came out.
   task automatic line(input logic dp, input logic dm);
      DP = dp; DM = dm;
      @(posedge clock); #1;
      if (out_valid === 1'b1) begin
         if (n_valid < 16) cap[n_valid] = out_bit;
         n_valid++;
      end
      if (pkt_start === 1'b1) n_start++;
      if (pkt_end === 1'b1) n_end++;
      if (line_error === 1'b1) n_lerr++;
      if (bs_error === 1'b1) n_bserr++;
      if (int'(pkt_start === 1'b1) + int'(pkt_end === 1'b1) +
          int'(line_error === 1'b1) + int'(bs_error === 1'b1) > 1) n_multi++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) line(1'b1, 1'b0);
   endtask

   // NRZI transmit: a 0 toggles the line, a 1 holds it.
   task automatic send_bit(input logic b);
      if (!b) tx_j = ~tx_j;
      line(tx_j, ~tx_j);
   endtask

   task automatic send_sync();
      tx_j = 1'b1;
      for (int i = 0; i < 7; i++) send_bit(1'b0);
      send_bit(1'b1);
   endtask

   task automatic test_reset();
      clr();
      reset_n = 1'b0;
      idle(2);
      total++; if ({out_bit, out_valid, pkt_start, pkt_end, line_error, bs_error} !== 6'b0) begin
         bad++; $display("FAIL reset_outputs: got %b want 000000",
            {out_bit, out_valid, pkt_start, pkt_end, line_error, bs_error});
      end
      reset_n = 1'b1;
      idle(3);
      total++; if (n_valid + n_start + n_end + n_lerr + n_bserr !== 0) begin
         bad++; $display("FAIL reset_idle_quiet: got %0d events want 0",
            n_valid + n_start + n_end + n_lerr + n_bserr);
      end
   endtask

   // Full packet: SYNC, 0xC3, SE0 SE0 J.
   task automatic test_c3(input string tag);
      logic [7:0] byte_v;
      byte_v = 8'hC3;
      clr();
      idle(2);
      send_sync();
      total++; if (pkt_start !== 1'b1) begin
         bad++; $display("FAIL %s_pkt_start: got %b want 1", tag, pkt_start);
      end
      for (int i = 0; i < 8; i++) send_bit(byte_v[i]);
      line(1'b0, 1'b0);
      total++; if (out_valid !== 1'b0) begin
         bad++; $display("FAIL %s_se0_valid: got %b want 0", tag, out_valid);
      end
      line(1'b0, 1'b0);
      line(1'b1, 1'b0);
      total++; if (pkt_end !== 1'b1) begin
         bad++; $display("FAIL %s_pkt_end: got %b want 1", tag, pkt_end);
      end
      idle(2);
      total++; if (n_valid !== 8) begin
         bad++; $display("FAIL %s_valid_count: got %0d want 8", tag, n_valid);
      end
      total++; if (cap[7:0] !== 8'hC3) begin
         bad++; $display("FAIL %s_data: got %h want c3", tag, cap[7:0]);
      end
      total++; if (n_start !== 1 || n_end !== 1) begin
         bad++; $display("FAIL %s_pulse_counts: got start=%0d end=%0d want 1/1", tag, n_start, n_end);
      end
      total++; if (n_lerr !== 0 || n_bserr !== 0 || n_multi !== 0) begin
         bad++; $display("FAIL %s_no_errors: got lerr=%0d bserr=%0d multi=%0d want 0",
            tag, n_lerr, n_bserr, n_multi);
      end
   endtask

   task automatic test_stuffing();
      clr();
      idle(2);
      send_sync();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      send_bit(1'b0);
      total++; if (out_valid !== 1'b0) begin
         bad++; $display("FAIL stuff_dropped: got out_valid=%b want 0", out_valid);
      end
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      total++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin
         bad++; $display("FAIL stuff_resume: got valid=%b bit=%b want 1/1", out_valid, out_bit);
      end
      line(1'b0, 1'b0); line(1'b0, 1'b0); line(1'b1, 1'b0);
      idle(2);
      total++; if (n_valid !== 8 || cap[7:0] !== 8'hFF) begin
         bad++; $display("FAIL stuff_data: got n=%0d data=%h want 8/ff", n_valid, cap[7:0]);
      end
      total++; if (n_end !== 1 || n_lerr !== 0) begin
         bad++; $display("FAIL stuff_eop: got end=%0d lerr=%0d want 1/0", n_end, n_lerr);
      end
   endtask

   task automatic test_bs_violation();
      clr();
      idle(2);
      send_sync();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      send_bit(1'b1);
`ifdef RX_BS_ERROR_EN
      total++; if (bs_error !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bs_pulse: got bs=%b valid=%b want 1/0", bs_error, out_valid);
      end
`else
      total++; if (bs_error !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bs_dropped: got bs=%b valid=%b want 0/0", bs_error, out_valid);
      end
`endif
      send_bit(1'b0);
      send_bit(1'b1);
      line(1'b0, 1'b0); line(1'b0, 1'b0); line(1'b1, 1'b0);
      idle(2);
`ifdef RX_BS_ERROR_EN
      total++; if (n_end !== 0 || n_bserr !== 1 || n_valid !== 5) begin
         bad++; $display("FAIL bs_abort: got end=%0d bs=%0d n=%0d want 0/1/5", n_end, n_bserr, n_valid);
      end
`else
      total++; if (n_end !== 1 || n_valid !== 7 || cap[6:0] !== 7'b1011111) begin
         bad++; $display("FAIL bs_continue: got end=%0d n=%0d data=%b want 1/7/1011111",
            n_end, n_valid, cap[6:0]);
      end
`endif
   endtask

   task automatic test_broken_sync();
      clr();
      idle(2);
      line(1'b0, 1'b1); line(1'b1, 1'b0); line(1'b0, 1'b1); line(1'b0, 1'b1);
      idle(3);
      total++; if (n_start !== 0 || n_valid !== 0 || n_lerr !== 0) begin
         bad++; $display("FAIL broken_sync: got start=%0d valid=%0d lerr=%0d want 0/0/0",
            n_start, n_valid, n_lerr);
      end
      test_c3("after_broken_sync");
   endtask

   task automatic test_line_errors();
      clr();
      idle(2);
      send_sync();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      line(1'b0, 1'b0);
      line(1'b1, 1'b0);
      total++; if (line_error !== 1'b1 || pkt_end !== 1'b0) begin
         bad++; $display("FAIL short_eop: got lerr=%b end=%b want 1/0", line_error, pkt_end);
      end
      idle(2);
      total++; if (n_lerr !== 1 || n_end !== 0) begin
         bad++; $display("FAIL short_eop_counts: got lerr=%0d end=%0d want 1/0", n_lerr, n_end);
      end
      clr();
      send_sync();
      send_bit(1'b1); send_bit(1'b0);
      line(1'b1, 1'b1);
      total++; if (line_error !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL se1_data: got lerr=%b valid=%b want 1/0", line_error, out_valid);
      end
      idle(2);
      total++; if (n_lerr !== 1 || n_valid !== 2 || n_multi !== 0) begin
         bad++; $display("FAIL se1_counts: got lerr=%0d n=%0d multi=%0d want 1/2/0",
            n_lerr, n_valid, n_multi);
      end
   endtask

   task automatic test_reset_mid();
      clr();
      idle(2);
      send_sync();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      total++; if (out_valid !== 1'b1 || out_bit !== 1'b0) begin
         bad++; $display("FAIL pre_reset_bit: got valid=%b bit=%b want 1/0", out_valid, out_bit);
      end
      reset_n = 1'b0;
      #1;
      total++; if ({out_bit, out_valid, pkt_start, pkt_end, line_error, bs_error} !== 6'b0) begin
         bad++; $display("FAIL async_reset: got %b want 000000",
            {out_bit, out_valid, pkt_start, pkt_end, line_error, bs_error});
      end
      line(1'b1, 1'b0);
      reset_n = 1'b1;
      test_c3("after_reset");
   endtask

   task automatic test_rx_disable();
      clr();
      idle(2);
      send_sync();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      rx_enable = 1'b0;
      send_bit(1'b1);
      total++; if (out_valid !== 1'b0 || line_error !== 1'b0 || pkt_end !== 1'b0) begin
         bad++; $display("FAIL rx_disable: got valid=%b lerr=%b end=%b want 0/0/0",
            out_valid, line_error, pkt_end);
      end
      idle(2);
      rx_enable = 1'b1;
      total++; if (n_end !== 0 || n_lerr !== 0) begin
         bad++; $display("FAIL rx_disable_quiet: got end=%0d lerr=%0d want 0/0", n_end, n_lerr);
      end
      test_c3("after_disable");
   endtask

   initial begin
      tx_j = 1'b1;
      test_reset();
      test_c3("basic");
      test_stuffing();
      test_bs_violation();
      test_broken_sync();
      test_line_errors();
      test_reset_mid();
      test_rx_disable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dpdm_nrzi_bs_decode.md
DPDM_NRZI_BS_DECODE -- requirements
Module: dpdm_nrzi_bs_decode

Interface
REQ-001 clock  input  1  system clock; one USB bit time per cycle.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 rx_enable  input  1  receiver armed; when low the block stays in or returns to IDLE.
REQ-004 DP  input  1  bus D+ sample.
REQ-005 DM  input  1  bus D- sample.
REQ-006 out_bit  output  1  decoded, unstuffed data bit to the downstream CRC checker.
REQ-007 out_valid  output  1  out_bit is a data bit this cycle.
REQ-008 pkt_start  output  1  one-cycle pulse when a valid SYNC completes.
REQ-009 pkt_end  output  1  one-cycle pulse when a valid EOP completes.
REQ-010 line_error  output  1  one-cycle pulse on a malformed EOP or SE1.
REQ-011 bs_error  output  1  one-cycle pulse on a bit-stuff violation; present only per REQ-028.

Function
REQ-012 Line states SHALL decode as J = DP1/DM0, K = DP0/DM1, SE0 = 0/0, SE1 = 1/1; idle line is J.
REQ-013 NRZI decode SHALL use the previous non-SE0 line level (J after reset or IDLE): same level -> 1, change -> 0.
REQ-014 FSM states SHALL be IDLE, SYNC, DATA, EOP; every output is registered, so the response to the sample taken at edge N is visible after edge N.
REQ-015 IDLE: K with rx_enable=1 -> SYNC with sync bit count 1; any other input -> stay IDLE.
REQ-016 SYNC: sync bits 2-7 SHALL decode 0 and bit 8 SHALL decode 1 (line KJKJKJKK); a mismatch or SE0 -> IDLE silently.
REQ-017 On bit 8 = 1: pulse pkt_start, enter DATA, set ones-run counter to 1.
REQ-018 DATA, non-SE0 bit b with run < 6: out_bit=b, out_valid=1; run = b ? run+1 : 0.
REQ-019 DATA, run == 6, b == 0: stuffed bit dropped (out_valid=0 that cycle), run = 0.
REQ-020 DATA, run == 6, b == 1: handled per REQ-028.
REQ-021 DATA, SE0: out_valid=0, enter EOP with SE0 count 1.
REQ-022 EOP: second SE0 -> stay (count 2); then J -> pulse pkt_end, IDLE; any other sequence (J after one SE0, K, third SE0, SE1) -> pulse line_error, IDLE.
REQ-023 SE1 in SYNC or DATA SHALL pulse line_error and return to IDLE; SE1 in IDLE is ignored.
REQ-024 rx_enable low in any state SHALL force IDLE on the next edge with no pkt_end, no error pulse, out_valid=0.
REQ-025 pkt_start, pkt_end, line_error, bs_error SHALL never assert in the same cycle as each other.

Reset
REQ-026 On reset_n low: state IDLE, previous level J, counters 0, and out_bit, out_valid, pkt_start, pkt_end, line_error, bs_error all 0, immediately and asynchronously.
REQ-027 Reset mid-packet SHALL discard the packet; the first SYNC after release is decoded normally.

Configuration
REQ-028 Macro RX_BS_ERROR_EN: defined -> REQ-020 pulses bs_error and returns to IDLE; undefined -> bs_error tied 0, the bit is dropped as in REQ-019 with run = 0, and DATA continues.

Verification
REQ-029 SYNC KJKJKJKK, then NRZI for byte 0xC3 LSB-first, SE0 SE0 J -> pkt_start once; out_valid for 8 cycles with bits 1,1,0,0,0,0,1,1; pkt_end once; no errors.
REQ-030 SYNC then data 0xFF with correct stuffing -> 8 valid ones; out_valid low for exactly one cycle after the 5th data one (6th of the run counting the SYNC 1).
REQ-031 SYNC then 6 ones plus an unstuffed 7th one -> with RX_BS_ERROR_EN: bs_error pulse, IDLE, no pkt_end; without: bit dropped, decoding continues.
REQ-032 Line KJKK (broken SYNC) -> no pkt_start, no out_valid, state IDLE.
REQ-033 SYNC, 4 data bits, SE0, J -> line_error pulse, no pkt_end; SE1 mid-DATA -> line_error pulse.
REQ-034 reset_n low for 1 cycle, or rx_enable low, mid-DATA -> outputs 0, IDLE; a following full packet decodes per REQ-029.
